arith_issue_arbiter: RTL and testbench
======================================

# arith_issue_arbiter

Shares one pipelined arithmetic datapath (16-bit operands, 2-bit op select, fixed 4-cycle result latency, no backpressure) among NUM_REQ requesters. Each cycle, a round-robin arbiter grants at most one requester. It registers that requester's operands onto the datapath issue port and records the requester's ID in a tag FIFO. When the datapath result returns, the arbiter pops the tag and routes the result back to the originating requester. The block sits between the requester fabric and the arithmetic host's a_in/b_in/op_sel/valid_in and result_out/valid_out ports.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- TAG_DEPTH, 8: tag FIFO depth and maximum in-flight operations; power of two, ≥ 5

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  0 = grant nothing new; in-flight operations still complete
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant, combinational
- req_a  in  16*NUM_REQ  operand A, requester i at [16i+15:16i]
- req_b  in  16*NUM_REQ  operand B, same packing
- req_op  in  2*NUM_REQ  op: 00 add, 01 sub, 10 mul, 11 and
- alu_a  out  16  operand A to datapath
- alu_b  out  16  operand B to datapath
- alu_op  out  2  op select to datapath
- alu_valid  out  1  issue strobe to datapath
- alu_result  in  16  datapath result
- alu_result_valid  in  1  datapath result strobe
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_data  out  16  response data
- inflight  out  clog2(TAG_DEPTH)+1  current in-flight count
- busy  out  1  inflight != 0
- err_underflow  out  1  sticky; a result arrived with the tag FIFO empty

## Operation
- A transfer occurs on any cycle where req_valid[i] and req_ready[i] are both 1.
- At most one req_ready bit is set. It is set only when all of the following hold:
  - enable is 1;
  - rst is 0;
  - inflight < TAG_DEPTH, or a tag pop occurs in the same cycle.
- Round-robin: the search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant updates only on a transfer. Reset sets last_grant = NUM_REQ-1, so requester 0 has first priority.
- On a transfer:
  - alu_a/alu_b/alu_op are registered from the granted requester's slice, and alu_valid = 1 on the next cycle;
  - the granted ID is pushed to the tag FIFO.
- With no transfer, alu_valid = 0 and alu_a/alu_b/alu_op hold their previous values.
- On alu_result_valid:
  - pop a tag, then register rsp_data = alu_result and rsp_valid = one-hot(tag) on the next cycle;
  - if the FIFO is empty: rsp_valid stays 0, err_underflow sets, and inflight does not change.
- Simultaneous push and pop: both occur; inflight is unchanged; FIFO order is preserved.
- inflight increments on a push and decrements on a valid pop. It never exceeds TAG_DEPTH.
- Responses have no backpressure. Requesters must accept rsp_valid whenever it is asserted.
- The op field passes through unmodified; arithmetic is performed by the datapath, not by this block.

## Timing
- Transfer on edge T → alu_valid high in cycle T+1.
- Datapath result_valid at T+5 → rsp_valid at T+6.
- Request-to-response latency is 6 cycles. Sustained throughput is 1 operation per cycle.
- Reset values: req_ready = 0, alu_a/alu_b = 0, alu_op = 00, alu_valid = 0, rsp_valid = 0, rsp_data = 0, inflight = 0, busy = 0, err_underflow = 0. The FIFO pointers clear.
- Reset mid-operation discards all tags. Results arriving after reset with the FIFO empty set err_underflow; the datapath shares rst, so this does not occur in-system.
- enable falling does not cancel a transfer already completed on that edge.

## Configuration
- ARB_PERF_CNT_EN defined:
  - adds input perf_sel [clog2(NUM_REQ)-1:0] and output perf_count [15:0];
  - keeps a 16-bit transfer counter per requester, reset to 0, wrapping at 0xFFFF→0;
  - perf_count is a registered read of counter[perf_sel] with 1-cycle latency.
- ARB_PERF_CNT_EN undefined: the counters and both ports are absent; all other behaviour is identical.

## Test plan
The bench uses a behavioral 4-cycle datapath returning the true arithmetic result.
- Single request, requester 0: a=3, b=5, op=00 → alu_valid at T+1 with alu_a=3, alu_b=5; rsp_valid=0001, rsp_data=8 at T+6.
- All four requesters hold valid, ops mul 2×3, sub 9−4, and 0xF0F0&0x0FF0, add 1+1 → grants in order 0,1,2,3 on consecutive cycles; responses 6, 5, 0x00F0, 2 on consecutive cycles with rsp_valid 0001, 0010, 0100, 1000.
- Requester 1 streams continuously and datapath results are held off → after 8 transfers, req_ready=0 and inflight=8; the first result returned re-enables a grant in the same cycle.
- enable=0 with req_valid=1111 → no grant and alu_valid stays 0; enable=1 → requester 0 is granted first.
- alu_result_valid pulsed after reset with no issues → err_underflow=1 and stays set, rsp_valid stays 0; rst clears it.
- With ARB_PERF_CNT_EN: 3 transfers from requester 2, then perf_sel=2 → perf_count=3 one cycle later; perf_sel=0 → 0.

Source files
------------

// File: rtl/arith_issue_arbiter.sv
// -----------------------------------------------------------------------------
// arith_issue_arbiter
//
// Shares one pipelined arithmetic datapath (fixed 4-cycle latency, no
// backpressure) among NUM_REQ requesters. A round-robin arbiter grants at most
// one requester per cycle and registers its operands onto the datapath issue
// port. The granted ID goes into a tag FIFO. Each returning result pops a tag
// and is steered back to the requester that issued it.
//
// Optional feature macro: ARB_PERF_CNT_EN
//   Adds one 16-bit transfer counter per requester, plus the perf_sel and
//   perf_count ports that read the counters.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   TAG_DEPTH  tag FIFO depth = max in-flight operations (power of two, >= 5)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   enable            0 = grant nothing new (in-flight work still completes)
//   req_valid/ready   per-requester request / one-hot combinational grant
//   req_a/req_b/op    packed per-requester operands (16/16/2 bits each)
//   alu_a/b/op/valid  registered issue port toward the datapath
//   alu_result(_valid) datapath return path
//   rsp_valid/rsp_data one-hot response strobe and data back to requesters
//   inflight, busy    outstanding operation count and its non-zero flag
//   err_underflow     sticky: a result arrived while no tag was outstanding
//   perf_sel/count    (ARB_PERF_CNT_EN only) registered counter read port
// -----------------------------------------------------------------------------
module arith_issue_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [16*NUM_REQ-1:0]        req_a,
    input  logic [16*NUM_REQ-1:0]        req_b,
    input  logic [2*NUM_REQ-1:0]         req_op,
    output logic [15:0]                  alu_a,
    output logic [15:0]                  alu_b,
    output logic [1:0]                   alu_op,
    output logic                         alu_valid,
    input  logic [15:0]                  alu_result,
    input  logic                         alu_result_valid,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [15:0]                  rsp_data,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    output logic                         busy,
    output logic                         err_underflow
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]   perf_sel,
    output logic [15:0]                  perf_count
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(TAG_DEPTH);
    localparam int CW  = PW + 1;

    // Unpacked views of the per-requester operand slices.
    logic [15:0] a_arr  [NUM_REQ];
    logic [15:0] b_arr  [NUM_REQ];
    logic [1:0]  op_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[16*g +: 16];
        assign b_arr[g]  = req_b[16*g +: 16];
        assign op_arr[g] = req_op[2*g +: 2];
    end

    // Registered state.
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [15:0]        alu_a_q, alu_a_d;
    logic [15:0]        alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_valid_q, alu_valid_d;
    logic [IDW-1:0]     tag_mem_q [TAG_DEPTH];
    logic [IDW-1:0]     tag_mem_d [TAG_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    // Arbitration and handshake signals.
    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               issue_ok;
    logic               transfer;

    assign fifo_empty = (inflight_q == '0);
    assign fifo_full  = (inflight_q == CW'(TAG_DEPTH));
    assign pop        = alu_result_valid && !fifo_empty;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    // a grant when a result is returning.
    assign issue_ok   = enable && !rst && (!fifo_full || pop);
    assign transfer   = issue_ok && grant_found;

    // Round-robin search: start one past the last granted requester and wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    // Issue path and tag FIFO.
    always_comb begin
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_valid_d  = transfer;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_mem_d[i] = tag_mem_q[i];
        end

        if (transfer) begin
            last_grant_d        = grant_id;
            alu_a_d             = a_arr[grant_id];
            alu_b_d             = b_arr[grant_id];
            alu_op_d            = op_arr[grant_id];
            tag_mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({transfer, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Response path. A result with no outstanding tag is dropped and flagged.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (pop) begin
            rsp_valid_d = NUM_REQ'(1) << tag_mem_q[rd_ptr_q];
            rsp_data_d  = alu_result;
        end
        if (alu_result_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_valid_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_valid_q  <= alu_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= tag_mem_d[i];
            end
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign alu_valid     = alu_valid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign inflight      = inflight_q;
    assign busy          = !fifo_empty;
    assign err_underflow = err_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_cnt_q [NUM_REQ];
    logic [15:0] perf_cnt_d [NUM_REQ];
    logic [15:0] perf_count_q, perf_count_d;

    // Counters wrap naturally at 0xFFFF. The read mux compares against each
    // index so that perf_sel values beyond NUM_REQ-1 read as zero.
    always_comb begin
        perf_count_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_cnt_d[i] = perf_cnt_q[i];
            if (transfer && (grant_id == IDW'(i))) begin
                perf_cnt_d[i] = perf_cnt_q[i] + 16'd1;
            end
            if (perf_sel == IDW'(i)) begin
                perf_count_d = perf_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_count_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_cnt_q[i] <= '0;
            end
        end else begin
            perf_count_q <= perf_count_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_cnt_q[i] <= perf_cnt_d[i];
            end
        end
    end

    assign perf_count = perf_count_q;
`endif

endmodule

// File: tb/tb_arith_issue_arbiter.sv
module tb_arith_issue_arbiter;

    localparam int NR = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            enable;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [16*NR-1:0] req_a;
    logic [16*NR-1:0] req_b;
    logic [2*NR-1:0] req_op;
    logic [15:0]     alu_a;
    logic [15:0]     alu_b;
    logic [1:0]      alu_op;
    logic            alu_valid;
    logic [15:0]     alu_result;
    logic            alu_result_valid;
    logic [NR-1:0]   rsp_valid;
    logic [15:0]     rsp_data;
    logic [3:0]      inflight;
    logic            busy;
    logic            err_underflow;
`ifdef ARB_PERF_CNT_EN
    logic [1:0]      perf_sel;
    logic [15:0]     perf_count;
`endif

    arith_issue_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_op           (req_op),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_op           (alu_op),
        .alu_valid        (alu_valid),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .inflight         (inflight),
        .busy             (busy),
        .err_underflow    (err_underflow)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_sel         (perf_sel),
        .perf_count       (perf_count)
`endif
    );

    function automatic logic [15:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return 16'(a * b);
            default: return a & b;
        endcase
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural datapath: each issue returns its true result 4 cycles later,
    // or later still while dp_hold is set (then one result per cycle).
    logic        dp_hold;
    logic        dp_valid = 1'b0;
    logic [15:0] dp_data  = 16'h0;
    logic        inj_valid;
    logic [15:0] inj_data;
    int          dp_cyc = 0;
    int          dp_due[$];
    logic [15:0] dp_val[$];

    always @(posedge clk) begin
        dp_cyc = dp_cyc + 1;
        if (rst) begin
            dp_due.delete();
            dp_val.delete();
            dp_valid <= 1'b0;
        end else begin
            if (alu_valid) begin
                dp_due.push_back(dp_cyc + 3);
                dp_val.push_back(alu_fn(alu_a, alu_b, alu_op));
            end
            if (dp_due.size() > 0 && dp_due[0] <= dp_cyc && !dp_hold) begin
                dp_valid <= 1'b1;
                dp_data  <= dp_val.pop_front();
                void'(dp_due.pop_front());
            end else begin
                dp_valid <= 1'b0;
            end
        end
    end

    assign alu_result_valid = dp_valid | inj_valid;
    assign alu_result       = inj_valid ? inj_data : dp_data;

    // Reference model: spec-level arbitration rules plus an expected-response
    // queue filled in grant order.
    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          m_last;
    int          m_cnt;
    bit          m_err;
    bit          m_pv;
    bit          m_after_rst;
    logic [15:0] m_pa, m_pb;
    logic [1:0]  m_po;
    logic [15:0] m_perf [NR];
    logic [15:0] m_perf_exp;
    logic [NR-1:0] exp_ready;
    bit          m_pop;
    int          gid;
    exp_t        e_new;

    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", 32'(req_ready), 32'h0);
            m_last      = NR - 1;
            m_cnt       = 0;
            m_err       = 1'b0;
            m_pv        = 1'b0;
            m_after_rst = 1'b1;
            m_perf_exp  = 16'h0;
            for (int i = 0; i < NR; i++) m_perf[i] = 16'h0;
            sb.delete();
        end else begin
            if (m_after_rst) begin
                chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                chk("rst_rsp_data", 32'(rsp_data), 32'h0);
                chk("rst_alu_a", 32'(alu_a), 32'h0);
                chk("rst_alu_b", 32'(alu_b), 32'h0);
                chk("rst_alu_op", 32'(alu_op), 32'h0);
                m_after_rst = 1'b0;
            end
            chk("inflight", 32'(inflight), 32'(m_cnt));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("err_underflow", 32'(err_underflow), 32'(m_err));
            chk("alu_valid", 32'(alu_valid), 32'(m_pv));
            if (m_pv) begin
                chk("alu_a", 32'(alu_a), 32'(m_pa));
                chk("alu_b", 32'(alu_b), 32'(m_pb));
                chk("alu_op", 32'(alu_op), 32'(m_po));
            end
`ifdef ARB_PERF_CNT_EN
            chk("perf_count", 32'(perf_count), 32'(m_perf_exp));
            m_perf_exp = 16'h0;
            for (int i = 0; i < NR; i++) if (32'(perf_sel) == i) m_perf_exp = m_perf[i];
`endif
            m_pop = alu_result_valid && (m_cnt > 0);
            if (alu_result_valid && m_cnt == 0) m_err = 1'b1;

            gid = -1;
            if (enable && (m_cnt < TD || m_pop)) begin
                for (int k = 1; k <= NR; k++) begin
                    if (gid < 0 && ((req_valid >> ((m_last + k) % NR)) & 1) != 0)
                        gid = (m_last + k) % NR;
                end
            end
            exp_ready = '0;
            if (gid >= 0) exp_ready = NR'(1) << gid;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));

            m_pv = (gid >= 0);
            if (gid >= 0) begin
                m_pa       = 16'(req_a >> (16 * gid));
                m_pb       = 16'(req_b >> (16 * gid));
                m_po       = 2'(req_op >> (2 * gid));
                e_new.id   = gid;
                e_new.data = alu_fn(m_pa, m_pb, m_po);
                sb.push_back(e_new);
                m_last = gid;
                m_cnt++;
                for (int i = 0; i < NR; i++) if (i == gid) m_perf[i] = m_perf[i] + 16'd1;
            end
            if (m_pop) m_cnt--;
        end
    end

    // Monitor: pops the expected queue whenever the DUT presents a response.
    bit   done     = 1'b0;
    bit   done_chk = 1'b0;
    exp_t e_got;

    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e_got = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(NR'(1) << e_got.id));
                chk("rsp_data", 32'(rsp_data), 32'(e_got.data));
            end
        end
        if (done && !done_chk) begin
            chk("sb_drained", 32'(sb.size()), 32'h0);
            done_chk = 1'b1;
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        dp_hold   = 1'b0;
        inj_valid = 1'b0;
        inj_data  = 16'h0;
`ifdef ARB_PERF_CNT_EN
        perf_sel  = 2'd0;
`endif
        idle(3);
        rst = 1'b0;
        idle(1);

        // Single request from requester 0: 3 + 5.
        req_a     = {48'h0, 16'd3};
        req_b     = {48'h0, 16'd5};
        req_op    = 8'h00;
        req_valid = 4'b0001;
        idle(1);
        req_valid = '0;
        idle(10);

        // All four at once: 2*3, 9-4, F0F0&0FF0, 1+1.
        req_a     = {16'd1, 16'hF0F0, 16'd9, 16'd2};
        req_b     = {16'd1, 16'h0FF0, 16'd4, 16'd3};
        req_op    = {2'b00, 2'b11, 2'b01, 2'b10};
        req_valid = 4'b1111;
        idle(4);
        req_valid = '0;
        idle(12);

        // Requester 1 streams while results are held off: fills the FIFO.
        dp_hold   = 1'b1;
        req_valid = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            req_a  = {$urandom, $urandom};
            req_b  = {$urandom, $urandom};
            req_op = 8'($urandom);
            idle(1);
        end
        dp_hold = 1'b0;
        idle(5);
        req_valid = '0;
        idle(20);

        // enable low blocks grants; after reset requester 0 wins first.
        do_reset();
        enable    = 1'b0;
        req_valid = 4'b1111;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        idle(5);
        enable = 1'b1;
        idle(4);
        req_valid = '0;
        idle(12);

        // Randomized traffic with random enable and result hold-off.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            enable    = ($urandom_range(0, 7) != 0);
            dp_hold   = ($urandom_range(0, 2) == 0);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            req_op    = 8'($urandom);
            idle(1);
        end
        req_valid = '0;
        enable    = 1'b1;
        dp_hold   = 1'b0;
        idle(30);

        // Result with no outstanding tag: sticky error, no response.
        inj_data  = 16'hBEEF;
        inj_valid = 1'b1;
        idle(1);
        inj_valid = 1'b0;
        idle(5);
        do_reset();
        idle(3);

`ifdef ARB_PERF_CNT_EN
        perf_sel  = 2'd2;
        req_valid = 4'b0100;
        idle(3);
        req_valid = '0;
        idle(3);
        perf_sel = 2'd0;
        idle(3);
        req_valid = 4'b0001;
        idle(2);
        req_valid = '0;
        idle(12);
`endif

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
